instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Instruction-side counterpart of controlpath. Owns the program counter, fetches 16-bit
//  instructions from synchronous-read instruction memory and presents current_instruction
//  to controlpath. Acts on controlpath's replies (advance, jump, halt). On halt (NULL SWCL)
//  it stops issuing instructions until the user_clock button produces a rising edge.
// PARAMETERS
//  ADDR_W    8      program counter / instruction memory address width
//  RESET_PC  0      program counter value loaded on reset
// PORTS
//  clock                      in   1       system clock, all state on rising edge
//  reset                      in   1       synchronous, active-high
//  user_clock                 in   1       async push-button level; rising edge resumes from HALT
//  program_counter_increment  in   1       from controlpath: instruction done, go to pc+1
//  jump_enable                in   1       from controlpath: instruction done, go to jump_target
//  jump_target                in   ADDR_W  branch destination, sampled with jump_enable
//  halt_request               in   1       from controlpath: stop after current instruction
//  mem_addr                   out  ADDR_W  instruction memory read address (= pc, combinational)
//  mem_data                   in   16      memory read data, valid 1 cycle after mem_addr sampled
//  current_instruction        out  16      instruction presented to controlpath (registered)
//  instruction_valid          out  1       current_instruction is live, controlpath may act
//  halted                     out  1       sequencer is in HALT
//  program_counter            out  ADDR_W  current pc, for debug / HEX display
// BEHAVIOUR
//  Reset (sync, high): pc=RESET_PC, state=FETCH, current_instruction=16'h0000,
//   instruction_valid=0, halted=0, user_clock synchroniser and edge registers cleared to 0.
//  Reset dominates everything, including mid-fetch and HALT.
//  States:
//   FETCH: mem_addr=pc. Memory samples the address at the end of the cycle. Next state LOAD.
//   LOAD:  current_instruction<=mem_data at end of cycle. Next state EXEC.
//   EXEC:  instruction_valid=1. Priority: halt_request > jump_enable > increment.
//      halt_request:              pc<=pc+1, go to HALT.
//      jump_enable:               pc<=jump_target, go to FETCH.
//      program_counter_increment: pc<=pc+1, go to FETCH.
//      none:                      stay in EXEC, so multi-cycle instructions hold.
//   HALT: instruction_valid=0, halted=1. Go to FETCH one cycle after a synchronised
//         rising edge of user_clock.
//  Control inputs (increment/jump/halt) are ignored outside EXEC.
//  Fetch latency: FETCH->LOAD->EXEC gives 2 cycles from pc update to instruction_valid.
//  user_clock: 2-flop synchroniser, then a registered edge detect (sync & ~prev).
//   A rising edge seen outside HALT is discarded, not queued.
//   A button held high through a halt does not resume; a fresh 0->1 transition is required.
//  pc arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 increments to 0.
//  instruction_valid deasserts on the cycle after EXEC is left.
//  current_instruction holds its last value until the next LOAD.
//  halted=1 only in HALT; it drops on the cycle FETCH is entered.
// TESTING
//  1 Reset, mem[0]=16'hE066: after 2 cycles instruction_valid=1, current_instruction=E066, pc=0.
//  2 Pulse increment in EXEC with mem[1]=16'hE027: valid low for 2 cycles, then E027, pc=1.
//  3 jump_enable with jump_target=8'h05 and increment in the same cycle: pc=5 (jump wins);
//    the following fetch shows mem[5].
//  4 halt_request with pc=2: halted=1, valid=0, pc=3. Hold for 20 cycles -> no fetch.
//    Drive user_clock 0 then 1 -> FETCH within 4 cycles, mem[3] presented.
//  5 user_clock toggled while in EXEC, then a halt: sequencer stays in HALT until a new edge.
//  6 pc=8'hFF plus increment -> pc=0. Assert reset during LOAD -> valid=0,
//    current_instruction=0, pc=RESET_PC on the next cycle.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Instruction-side sequencer: owns the pc, fetches from synchronous-read memory and
// hands each instruction to controlpath, parking in HALT until a user_clock press.
module instruction_sequencer #(
  parameter int unsigned            ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              user_clock,
  input  logic              program_counter_increment,
  input  logic              jump_enable,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt_request,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       current_instruction,
  output logic              instruction_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] program_counter
);

  typedef enum logic [1:0] {StFetch, StLoad, StExec, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [1:0]        sync_q;
  logic              prev_q;
  logic              edge_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      sync_q  <= {sync_q[0], user_clock};
      prev_q  <= sync_q[1];
      // Single-cycle pulse; if it lands outside HALT it is simply lost.
      edge_q  <= sync_q[1] & ~prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StFetch: state_d = StLoad;
      StLoad: begin
        instr_d = mem_data;
        state_d = StExec;
      end
      StExec: begin
        if (halt_request) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StHalt;
        end else if (jump_enable) begin
          pc_d    = jump_target;
          state_d = StFetch;
        end else if (program_counter_increment) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (edge_q) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign mem_addr            = pc_q;
  assign program_counter     = pc_q;
  assign current_instruction = instr_q;
  assign instruction_valid   = (state_q == StExec);
  assign halted              = (state_q == StHalt);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomised bench: a pc/memory reference model predicts each presented instruction,
// and a monitor compares them whenever instruction_valid rises.
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset, user_clock, inc, jmp, halt_req;
  logic [7:0]  jt, mem_addr, pc;
  logic [15:0] mem_data = '0;
  logic [15:0] instr;
  logic        valid, halted;

  logic [15:0] mem [256];

  instruction_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .user_clock                (user_clock),
    .program_counter_increment (inc),
    .jump_enable               (jmp),
    .jump_target               (jt),
    .halt_request              (halt_req),
    .mem_addr                  (mem_addr),
    .mem_data                  (mem_data),
    .current_instruction       (instr),
    .instruction_valid         (valid),
    .halted                    (halted),
    .program_counter           (pc)
  );

  always #5 clock = ~clock;
  always @(posedge clock) mem_data <= mem[mem_addr];

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] ins;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_pc;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void expect_at(int a);
    exp_t e;
    e.pc  = 8'(a);
    e.ins = mem[a];
    q.push_back(e);
  endfunction

  // Monitor: each fresh presentation must match the oldest prediction.
  logic pv = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (valid && !pv) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got pc=%0h ins=%0h expected none", pc, instr);
      end else begin
        e = q.pop_front();
        check("issue", {8'h0, pc, instr}, {8'h0, e.pc, e.ins});
      end
    end
    pv = valid;
  end

  task automatic wait_valid(input int exp_lat);
    int n = 0;
    while (!valid && n < 12) begin
      @(negedge clock);
      n++;
    end
    check("fetch_latency", n, exp_lat);
  endtask

  // Drive one controlpath reply for a cycle; for non-halt, predict the next issue.
  task automatic issue(input bit i, input bit j, input bit h, input logic [7:0] t);
    inc = i; jmp = j; halt_req = h; jt = t;
    if (h)      model_pc = (model_pc + 1) % 256;
    else if (j) model_pc = int'(t);
    else if (i) model_pc = (model_pc + 1) % 256;
    if (!h && (i || j)) expect_at(model_pc);
    @(negedge clock);
    inc = 0; jmp = 0; halt_req = 0; jt = $urandom_range(0, 255);
  endtask

  task automatic do_halt(input bit held_high, input bit j, input bit i);
    int hold;
    int bad = 0;
    int n = 0;
    if (held_high) begin
      user_clock = 0;
      repeat (4) @(negedge clock);
      user_clock = 1;
      repeat (6) @(negedge clock);
    end
    issue(i, j, 1'b1, 8'($urandom_range(0, 255)));
    check("halt_state", {29'h0, halted, valid, 1'b0}, {29'h0, 1'b1, 1'b0, 1'b0});
    check("halt_pc", pc, model_pc);
    hold = $urandom_range(5, 20);
    repeat (hold) begin
      @(negedge clock);
      if (!halted || valid) bad++;
    end
    check("halt_hold", bad, 0);
    user_clock = 0;
    repeat (3) @(negedge clock);
    user_clock = 1;
    expect_at(model_pc);
    while (halted && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("resume_latency", n, 4);
    wait_valid(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom());
    mem[0] = 16'hE066;
    mem[1] = 16'hE027;
    reset = 1; user_clock = 0; inc = 0; jmp = 0; halt_req = 0; jt = 0;
    model_pc = 0;
    repeat (3) @(negedge clock);
    check("rst_valid", valid, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);

    reset = 0;
    expect_at(0);
    wait_valid(2);

    issue(1, 0, 0, 0);
    wait_valid(2);
    issue(1, 1, 0, 8'h05);
    wait_valid(2);
    check("jump_pc", pc, 5);

    issue(0, 1, 0, 8'h02);
    wait_valid(2);
    do_halt(0, 0, 0);
    check("resume_pc", pc, 3);

    repeat (3) @(negedge clock);
    do_halt(1, 1, 1);

    issue(0, 1, 0, 8'hFF);
    wait_valid(2);
    issue(1, 0, 0, 0);
    wait_valid(2);
    check("wrap_pc", pc, 0);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      r = $urandom_range(0, 9);
      if (r == 0) do_halt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r <= 3) begin
        issue(1'($urandom_range(0, 1)), 1, 0, 8'($urandom_range(0, 255)));
        wait_valid(2);
      end else begin
        issue(1, 0, 0, 0);
        wait_valid(2);
      end
    end

    // Reset while the fetched word is being loaded.
    issue(1, 0, 0, 0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("ld_rst_valid", valid, 0);
    check("ld_rst_instr", instr, 0);
    check("ld_rst_pc", pc, 0);
    q.delete();
    model_pc = 0;
    reset = 0;
    expect_at(0);
    wait_valid(2);
    repeat (3) @(negedge clock);
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
